// File: rtl/wb_scoreboard.sv
// Register scoreboard with single-cycle ALU and long-latency writeback arbitration.
// Tracks pending long results, stalls dependent issues, and forwards the in-flight write.
module wb_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic        issue_long,
  output logic        issue_stall,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        wr_en,
  output logic [4:0]  wr_rd,
  output logic [31:0] wr_data,
  output logic        fwd1_hit,
  output logic        fwd2_hit,
  output logic [31:0] fwd_data,
  output logic [15:0] busy_vec,
  output logic        err
);

  logic [15:0] busy;
  logic [15:0] busy_next;
  logic [3:0]  rd_idx;
  logic [3:0]  rs1_idx;
  logic [3:0]  rs2_idx;
  logic [3:0]  alu_idx;
  logic [3:0]  lu_idx;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rd_busy;
  logic        issue_accept;
  logic        lu_handshake;
  logic        src_valid;
  logic [4:0]  src_rd;
  logic [31:0] src_data;
  logic        write_next;
  logic        err_event;

  // Only the low four bits select one of the sixteen tracked registers.
  assign rd_idx  = issue_rd[3:0];
  assign rs1_idx = issue_rs1[3:0];
  assign rs2_idx = issue_rs2[3:0];
  assign alu_idx = alu_rd[3:0];
  assign lu_idx  = lu_rd[3:0];

  assign rs1_busy = (rs1_idx != 4'd0) && busy[rs1_idx];
  assign rs2_busy = (rs2_idx != 4'd0) && busy[rs2_idx];
  assign rd_busy  = (rd_idx  != 4'd0) && busy[rd_idx];

  assign issue_stall  = issue_valid && !rst && (rs1_busy || rs2_busy || rd_busy);
  assign issue_accept = issue_valid && !issue_stall;

  // The ALU always wins the write port; the long unit waits for a free cycle.
  assign lu_ready     = !alu_valid && !rst;
  assign lu_handshake = lu_valid && lu_ready;

  always_comb begin
    src_valid = 1'b0;
    src_rd    = 5'd0;
    src_data  = 32'd0;
    if (alu_valid) begin
      src_valid = 1'b1;
      src_rd    = alu_rd;
      src_data  = alu_data;
    end else if (lu_handshake) begin
      src_valid = 1'b1;
      src_rd    = lu_rd;
      src_data  = lu_data;
    end
  end

  assign write_next = src_valid && (src_rd[3:0] != 4'd0);

  // Clear is applied before set so a coincident set on the same index wins.
  always_comb begin
    busy_next = busy;
    if (lu_handshake) begin
      busy_next[lu_idx] = 1'b0;
    end
    if (issue_accept && issue_long && (rd_idx != 4'd0)) begin
      busy_next[rd_idx] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  assign err_event = (lu_handshake && !busy[lu_idx])
                  || (alu_valid && (alu_idx != 4'd0) && busy[alu_idx])
                  || (alu_valid && lu_valid && (lu_idx == alu_idx));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 16'd0;
      wr_en   <= 1'b0;
      wr_rd   <= 5'd0;
      wr_data <= 32'd0;
      err     <= 1'b0;
    end else begin
      busy  <= busy_next;
      wr_en <= write_next;
      if (write_next) begin
        wr_rd   <= src_rd;
        wr_data <= src_data;
      end
      if (err_event) begin
        err <= 1'b1;
      end
    end
  end

  assign busy_vec = busy;

  // Bypass compares against the write currently on the register-file port.
  assign fwd1_hit = !rst && wr_en && (wr_rd[3:0] == rs1_idx) && (rs1_idx != 4'd0);
  assign fwd2_hit = !rst && wr_en && (wr_rd[3:0] == rs2_idx) && (rs2_idx != 4'd0);
  assign fwd_data = wr_data;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed self-checking bench for wb_scoreboard: issue stalls, arbitration,
// forwarding, error flag and reset behaviour with hand-computed expectations.
module tb_wb_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        issue_long;
  logic        issue_stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [31:0] fwd_data;
  logic [15:0] busy_vec;
  logic        err;

  int passed;
  int total;
  int failed;

  wb_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_long(issue_long), .issue_stall(issue_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data),
    .busy_vec(busy_vec), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected) begin
      passed++;
    end else begin
      failed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic iv, input logic [4:0] ird,
                                input logic [4:0] irs1, input logic [4:0] irs2,
                                input logic ilong);
    issue_valid = iv;
    issue_rd    = ird;
    issue_rs1   = irs1;
    issue_rs2   = irs2;
    issue_long  = ilong;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    failed = 0;
    rst = 1'b1;
    apply_stimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    lu_valid  = 1'b0; lu_rd  = 5'd0; lu_data  = 32'd0;
    tick();
    tick();

    check_output("reset_busy", 32'(busy_vec), 32'h0);
    check_output("reset_wr_en", 32'(wr_en), 32'h0);
    check_output("reset_wr_rd", 32'(wr_rd), 32'h0);
    check_output("reset_wr_data", wr_data, 32'h0);
    check_output("reset_err", 32'(err), 32'h0);
    lu_valid = 1'b1; lu_rd = 5'd3;
    check_output("reset_lu_ready", 32'(lu_ready), 32'h0);
    lu_valid = 1'b0; lu_rd = 5'd0;

    // Long issue to r5 followed by a dependent issue that must stall.
    rst = 1'b0;
    apply_stimulus(1'b1, 5'd5, 5'd0, 5'd0, 1'b1);
    #1;
    check_output("issue5_stall", 32'(issue_stall), 32'h0);
    tick();
    check_output("busy_r5", 32'(busy_vec), 32'h0020);
    apply_stimulus(1'b1, 5'd1, 5'd5, 5'd0, 1'b0);
    #1;
    check_output("dep_stall", 32'(issue_stall), 32'h1);
    lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 32'hA5A5_0005;
    #1;
    check_output("lu5_ready", 32'(lu_ready), 32'h1);
    tick();
    lu_valid = 1'b0;
    check_output("busy_clear5", 32'(busy_vec), 32'h0);
    check_output("lu5_wr_en", 32'(wr_en), 32'h1);
    check_output("lu5_wr_rd", 32'(wr_rd), 32'd5);
    check_output("lu5_wr_data", wr_data, 32'hA5A5_0005);
    check_output("dep_unstall", 32'(issue_stall), 32'h0);
    check_output("dep_fwd1", 32'(fwd1_hit), 32'h1);
    apply_stimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    check_output("idle_wr_en", 32'(wr_en), 32'h0);
    check_output("idle_wr_rd_hold", 32'(wr_rd), 32'd5);

    // ALU and long unit collide: ALU first, long write follows.
    apply_stimulus(1'b1, 5'd7, 5'd0, 5'd0, 1'b1);
    tick();
    apply_stimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check_output("busy_r7", 32'(busy_vec), 32'h0080);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0033;
    lu_valid  = 1'b1; lu_rd  = 5'd7; lu_data  = 32'h0000_0077;
    #1;
    check_output("collide_lu_ready", 32'(lu_ready), 32'h0);
    tick();
    alu_valid = 1'b0;
    check_output("alu3_wr_rd", 32'(wr_rd), 32'd3);
    check_output("alu3_wr_data", wr_data, 32'h33);
    check_output("busy_r7_held", 32'(busy_vec), 32'h0080);
    #1;
    check_output("lu7_ready", 32'(lu_ready), 32'h1);
    tick();
    lu_valid = 1'b0;
    check_output("lu7_wr_en", 32'(wr_en), 32'h1);
    check_output("lu7_wr_rd", 32'(wr_rd), 32'd7);
    check_output("lu7_wr_data", wr_data, 32'h77);
    check_output("busy_clear7", 32'(busy_vec), 32'h0);
    check_output("no_err_yet", 32'(err), 32'h0);

    // Writes to r0 are dropped and never forwarded.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD_BEEF;
    tick();
    alu_valid = 1'b0;
    apply_stimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    check_output("r0_wr_en", 32'(wr_en), 32'h0);
    check_output("r0_wr_data_hold", wr_data, 32'h77);
    check_output("r0_fwd1", 32'(fwd1_hit), 32'h0);
    check_output("r0_fwd2", 32'(fwd2_hit), 32'h0);

    // Bypass of the in-flight ALU write to r9; bit 4 of the index is ignored.
    apply_stimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_1234;
    tick();
    alu_valid = 1'b0;
    apply_stimulus(1'b1, 5'd0, 5'd2, 5'd9, 1'b0);
    #1;
    check_output("fwd2_hit", 32'(fwd2_hit), 32'h1);
    check_output("fwd1_miss", 32'(fwd1_hit), 32'h0);
    check_output("fwd_data", fwd_data, 32'h0000_1234);
    apply_stimulus(1'b1, 5'd0, 5'h19, 5'd0, 1'b0);
    #1;
    check_output("fwd1_bit4", 32'(fwd1_hit), 32'h1);
    check_output("fwd2_off", 32'(fwd2_hit), 32'h0);
    apply_stimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    // Long result to a register that was never marked busy.
    lu_valid = 1'b1; lu_rd = 5'd4; lu_data = 32'h0000_0044;
    tick();
    lu_valid = 1'b0;
    check_output("err_set", 32'(err), 32'h1);
    check_output("err4_wr_en", 32'(wr_en), 32'h1);
    check_output("err4_wr_rd", 32'(wr_rd), 32'd4);
    tick();
    check_output("err_sticky", 32'(err), 32'h1);

    // Pending long results on r10 (via bit-4 alias) and r6, then reset.
    apply_stimulus(1'b1, 5'h1A, 5'd0, 5'd0, 1'b1);
    tick();
    apply_stimulus(1'b1, 5'd6, 5'd0, 5'd0, 1'b1);
    tick();
    check_output("busy_r10_r6", 32'(busy_vec), 32'h0440);
    apply_stimulus(1'b1, 5'd0, 5'h0A, 5'd0, 1'b0);
    #1;
    check_output("stall_r10", 32'(issue_stall), 32'h1);
    apply_stimulus(1'b1, 5'd0, 5'd6, 5'd0, 1'b0);
    #1;
    check_output("stall_r6", 32'(issue_stall), 32'h1);
    rst = 1'b1;
    #1;
    check_output("rst_stall", 32'(issue_stall), 32'h0);
    tick();
    rst = 1'b0;
    check_output("rst_busy", 32'(busy_vec), 32'h0);
    check_output("rst_wr_en", 32'(wr_en), 32'h0);
    check_output("rst_err", 32'(err), 32'h0);
    #1;
    check_output("post_rst_stall", 32'(issue_stall), 32'h0);
    apply_stimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    // A stale long result after reset is still written but flags an error.
    lu_valid = 1'b1; lu_rd = 5'd6; lu_data = 32'h0000_0066;
    tick();
    lu_valid = 1'b0;
    check_output("stale_err", 32'(err), 32'h1);
    check_output("stale_wr_rd", 32'(wr_rd), 32'd6);

    // ALU write to a busy register is also a protocol error.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    apply_stimulus(1'b1, 5'd8, 5'd0, 5'd0, 1'b1);
    tick();
    apply_stimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check_output("pre_alu_err", 32'(err), 32'h0);
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h0000_0088;
    tick();
    alu_valid = 1'b0;
    check_output("alu_busy_err", 32'(err), 32'h1);
    check_output("alu_busy_kept", 32'(busy_vec), 32'h0100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
